// File: rtl/uart_rx_framer.sv
// uart_rx_framer
//   Receive-side UART front end, fixed 8N1, LSB first. The raw rx pin is
//   synchronised, start bits are detected on a falling edge, and every bit is
//   taken as the majority of three samples around the bit centre. A good stop
//   bit emits the byte as a one-cycle write strobe towards the rx FIFO. A bad
//   stop bit raises framingError. An all-zero frame with a bad stop bit is
//   reported as a line break.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   enable         receiver enable; low returns to IDLE and suppresses pulses
//   cyclesPerBit   bit period minus one in clk cycles, latched at each start bit
//   rx             raw asynchronous serial input, idle high
//   dataOut        last valid received byte, held between frames
//   dataAvailable  one-cycle strobe, dataOut carries a new byte
//   framingError   one-cycle strobe, stop bit sampled low
//   breakDetected  level, break seen; clears once the line has been high a bit time
//   busy           receiver is not in IDLE
module uart_rx_framer #(
  parameter int CLOCK_SCALE_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic                        rx,
  output logic [7:0]                  dataOut,
  output logic                        dataAvailable,
  output logic                        framingError,
  output logic                        breakDetected,
  output logic                        busy
);

  localparam int W = CLOCK_SCALE_BITS;
  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] MIN_PERIOD = W'(4);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

  state_e       state_q, state_d;
  logic         rx_meta_q, rxs_q, rxs_prev_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] mid;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [7:0]   shift_q, shift_d;
  logic [7:0]   data_out_q, data_out_d;
  logic         samp0_q, samp0_d, samp1_q, samp1_d;
  logic         data_avail_q, data_avail_d;
  logic         frame_err_q, frame_err_d;
  logic         break_q, break_d;
  logic         fall_edge, at_lo, at_mid, at_hi, at_end, majority;

  // Periods below 4 would put the first sample at or before count 0.
  function automatic logic [W-1:0] clamp_period(input logic [W-1:0] cpb);
    return (cpb < MIN_PERIOD) ? MIN_PERIOD : cpb;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign fall_edge = rxs_prev_q & ~rxs_q;
  assign mid       = period_q >> 1;
  assign at_lo     = (cnt_q == mid - CNT_ONE);
  assign at_mid    = (cnt_q == mid);
  assign at_hi     = (cnt_q == mid + CNT_ONE);
  assign at_end    = (cnt_q == period_q);
  // Third sample is the live synchronised value at count mid+1.
  assign majority  = maj3(samp0_q, samp1_q, rxs_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    samp0_d      = at_lo ? rxs_q : samp0_q;
    samp1_d      = at_mid ? rxs_q : samp1_q;
    data_avail_d = 1'b0;
    frame_err_d  = 1'b0;
    break_d      = break_q;

    case (state_q)
      IDLE: begin
        if (fall_edge) begin
          period_d = clamp_period(cyclesPerBit);
          cnt_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        cnt_d = at_end ? '0 : cnt_q + CNT_ONE;
        if (at_hi && majority) begin
          state_d = IDLE;
        end else if (at_end) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        cnt_d = at_end ? '0 : cnt_q + CNT_ONE;
        if (at_hi) begin
          shift_d[bit_idx_q] = majority;
        end
        if (at_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        // The decision comes at mid+1, which is always before the end of
        // the bit, so the counter never needs to wrap here. Leaving half a
        // bit early lets the next start bit be caught back-to-back.
        cnt_d = cnt_q + CNT_ONE;
        if (at_hi) begin
          if (majority) begin
            data_out_d   = shift_q;
            data_avail_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            if (shift_q == 8'h00) begin
              break_d = 1'b1;
              cnt_d   = '0;
              state_d = BREAK;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      BREAK: begin
        // Counts consecutive high cycles; any low cycle restarts the count.
        if (!rxs_q) begin
          cnt_d = '0;
        end else if (at_end) begin
          cnt_d   = '0;
          break_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d      = IDLE;
      break_d      = 1'b0;
      data_avail_d = 1'b0;
      frame_err_d  = 1'b0;
      data_out_d   = data_out_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= 3'd0;
      data_out_q   <= 8'h00;
      data_avail_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rxs_q        <= rx_meta_q;
      rxs_prev_q   <= rxs_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      data_out_q   <= data_out_d;
      data_avail_q <= data_avail_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
    end
  end

  // Datapath registers; always written before being used in a frame
  always_ff @(posedge clk) begin
    period_q <= period_d;
    shift_q  <= shift_d;
    samp0_q  <= samp0_d;
    samp1_q  <= samp1_d;
  end

  assign dataOut       = data_out_q;
  assign dataAvailable = data_avail_q;
  assign framingError  = frame_err_q;
  assign breakDetected = break_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
module tb_uart_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] cyclesPerBit = 16'd15;
  logic [7:0]  dataOut;
  logic        dataAvailable;
  logic        framingError;
  logic        breakDetected;
  logic        busy;

  uart_rx_framer #(.CLOCK_SCALE_BITS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cyclesPerBit (cyclesPerBit),
    .rx           (rx),
    .dataOut      (dataOut),
    .dataAvailable(dataAvailable),
    .framingError (framingError),
    .breakDetected(breakDetected),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         da_cnt = 0;
  int         fe_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] rxq[$];
  int         d0, f0;

  // Pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (dataAvailable) begin
      da_cnt <= da_cnt + 1;
      rxq.push_back(dataOut);
    end
    if (framingError) fe_cnt <= fe_cnt + 1;
    if (dataAvailable && framingError) both_cnt <= both_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] q_last();
    if (rxq.size() == 0) return 8'h00;
    return rxq[rxq.size() - 1];
  endfunction

  function automatic logic [7:0] q_at(input int i);
    if (i >= rxq.size()) return 8'h00;
    return rxq[i];
  endfunction

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // Drives one 10-bit frame, bl cycles per bit. glitch_cyc inverts rx for one
  // cycle, ncyc truncates the frame, cpb_cyc reprograms cyclesPerBit to 7.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int bl,
                            input int glitch_cyc, input int ncyc, input int cpb_cyc);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int c = 0; c < 10 * bl && c < ncyc; c++) begin
      @(negedge clk);
      rx = bits[c / bl] ^ (c == glitch_cyc);
      if (c == cpb_cyc) cyclesPerBit = 16'd7;
    end
  endtask

  task automatic mark();
    d0 = da_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    int q0;

    // Reset state
    hold(1'b1, 3);
    check_val("rst_dataOut", 32'(dataOut), 32'h00);
    check_val("rst_dataAvailable", 32'(dataAvailable), 32'h0);
    check_val("rst_framingError", 32'(framingError), 32'h0);
    check_val("rst_breakDetected", 32'(breakDetected), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    hold(1'b1, 5);

    // Back-to-back 0x55, 0xA3
    mark();
    q0 = rxq.size();
    send_frame(8'h55, 1'b1, 16, -1, 1000, -1);
    send_frame(8'hA3, 1'b1, 16, -1, 1000, -1);
    hold(1'b1, 20);
    check_val("b2b_count", da_cnt - d0, 2);
    check_val("b2b_byte0", 32'(q_at(q0)), 32'h55);
    check_val("b2b_byte1", 32'(q_at(q0 + 1)), 32'hA3);
    check_val("b2b_fe", fe_cnt - f0, 0);
    check_val("b2b_dataOut", 32'(dataOut), 32'hA3);

    // 3-cycle glitch on idle line
    mark();
    hold(1'b0, 3);
    hold(1'b1, 2);
    check_val("glitch_busy_hi", 32'(busy), 32'h1);
    hold(1'b1, 9);
    check_val("glitch_busy_lo", 32'(busy), 32'h0);
    hold(1'b1, 10);
    check_val("glitch_da", da_cnt - d0, 0);
    check_val("glitch_fe", fe_cnt - f0, 0);

    // 0xA5 with low stop bit
    mark();
    send_frame(8'hA5, 1'b0, 16, -1, 1000, -1);
    hold(1'b1, 30);
    check_val("ferr_fe", fe_cnt - f0, 1);
    check_val("ferr_da", da_cnt - d0, 0);
    check_val("ferr_dataOut", 32'(dataOut), 32'hA3);
    check_val("ferr_break", 32'(breakDetected), 32'h0);
    check_val("ferr_busy", 32'(busy), 32'h0);

    // 0x00 with one-cycle inversion at the centre of data bit 2
    mark();
    send_frame(8'h00, 1'b1, 16, 3 * 16 + 1 + 7, 1000, -1);
    hold(1'b1, 20);
    check_val("maj_da", da_cnt - d0, 1);
    check_val("maj_byte", 32'(q_last()), 32'h00);
    check_val("maj_dataOut", 32'(dataOut), 32'h00);
    check_val("maj_fe", fe_cnt - f0, 0);

    // Line break: 12 bit times low, then high, then 0x3C
    mark();
    hold(1'b0, 192);
    check_val("brk_level", 32'(breakDetected), 32'h1);
    check_val("brk_fe", fe_cnt - f0, 1);
    check_val("brk_da", da_cnt - d0, 0);
    check_val("brk_busy", 32'(busy), 32'h1);
    hold(1'b1, 10);
    check_val("brk_hold", 32'(breakDetected), 32'h1);
    hold(1'b1, 14);
    check_val("brk_clear", 32'(breakDetected), 32'h0);
    check_val("brk_idle", 32'(busy), 32'h0);
    mark();
    send_frame(8'h3C, 1'b1, 16, -1, 1000, -1);
    hold(1'b1, 20);
    check_val("brk_next_da", da_cnt - d0, 1);
    check_val("brk_next_byte", 32'(q_last()), 32'h3C);

    // Async reset in the middle of 0xFF
    mark();
    send_frame(8'hFF, 1'b1, 16, -1, 80, -1);
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    hold(1'b1, 2);
    check_val("mrst_dataOut", 32'(dataOut), 32'h00);
    check_val("mrst_busy", 32'(busy), 32'h0);
    check_val("mrst_da", 32'(dataAvailable), 32'h0);
    check_val("mrst_fe", 32'(framingError), 32'h0);
    check_val("mrst_break", 32'(breakDetected), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 20);
    send_frame(8'h12, 1'b1, 16, -1, 1000, -1);
    hold(1'b1, 20);
    check_val("mrst_count", da_cnt - d0, 1);
    check_val("mrst_byte", 32'(q_last()), 32'h12);

    // enable dropped in the middle of 0xFF
    mark();
    send_frame(8'hFF, 1'b1, 16, -1, 80, -1);
    @(negedge clk);
    enable = 1'b0;
    hold(1'b1, 3);
    check_val("dis_busy", 32'(busy), 32'h0);
    check_val("dis_dataOut", 32'(dataOut), 32'h12);
    hold(1'b1, 150);
    check_val("dis_da", da_cnt - d0, 0);
    @(negedge clk);
    enable = 1'b1;
    hold(1'b1, 10);
    send_frame(8'h12, 1'b1, 16, -1, 1000, -1);
    hold(1'b1, 20);
    check_val("dis_count", da_cnt - d0, 1);
    check_val("dis_byte", 32'(q_last()), 32'h12);
    check_val("dis_fe", fe_cnt - f0, 0);

    // Period below the minimum is clamped to 4 (5-cycle bits)
    mark();
    cyclesPerBit = 16'd2;
    send_frame(8'h96, 1'b1, 5, -1, 1000, -1);
    hold(1'b1, 20);
    check_val("clamp_count", da_cnt - d0, 1);
    check_val("clamp_byte", 32'(q_last()), 32'h96);

    // cyclesPerBit rewritten mid-frame is ignored until the next start bit
    mark();
    cyclesPerBit = 16'd15;
    send_frame(8'h5A, 1'b1, 16, -1, 1000, 40);
    hold(1'b1, 20);
    check_val("cpb_count", da_cnt - d0, 1);
    check_val("cpb_byte", 32'(q_last()), 32'h5A);
    cyclesPerBit = 16'd15;

    check_val("no_overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
